// File: rtl/compensate2_seq_if.sv
// Operand/result handshake bundle for compensate2_seq.
// The master side drives operands and accepts results; the slave side is the negator.
interface compensate2_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/compensate2_seq.sv
// Multi-cycle two's-complement unit: pass / negate / absolute value,
// CHUNK bits per cycle LSB first through a registered carry.
module compensate2_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  compensate2_seq_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("compensate2_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             res_ovf;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] d;
  logic [CHUNK:0]   sum;
  logic             last;
  logic             neg_in;

  // Chunk mux/demux written as constant-index loops so every slice is static.
  always_comb begin
    d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CW'(i)) d = opnd[i*CHUNK +: CHUNK];
    end
    sum = {1'b0, (neg ? ~d : d)} + {{CHUNK{1'b0}}, carry};
    acc_next = acc;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CW'(i)) acc_next[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end
    last   = (cnt == CW'(N - 1));
    neg_in = (bus.mode == 2'b01) || ((bus.mode == 2'b10) && bus.in_data[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      res         <= '0;
      res_ovf     <= 1'b0;
      cnt         <= '0;
      carry       <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            opnd       <= bus.in_data;
            neg        <= neg_in;
            carry      <= neg_in;
            ovf        <= neg_in && (bus.in_data == MOST_NEG);
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          carry <= sum[CHUNK];
          cnt   <= cnt + 1'b1;
          // Result is published only on entry to DONE so out_data holds the previous value meanwhile.
          if (last) begin
            res         <= acc_next;
            res_ovf     <= ovf;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = res;
  assign bus.out_ovf   = res_ovf;
endmodule

// File: tb/tb_compensate2_seq.sv
// Bench for compensate2_seq: vector table plus backpressure and reset-abort sequences,
// exercising a 32/8 chunked instance and an 8/8 single-pass instance.
module tb_compensate2_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  compensate2_seq_if #(.WIDTH(32)) b32 ();
  compensate2_seq_if #(.WIDTH(8))  b8 ();

  compensate2_seq #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  compensate2_seq #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    bit          w8;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [31:0] exp;
    bit          ovf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          ovf;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitors: pop an expectation on every output handshake.
  always @(negedge clk) begin
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL out32_unexpected: got 0x%08h, expected no result", b32.out_data);
      end else begin
        m32 = q32.pop_front();
        check("out32_data", b32.out_data, m32.data);
        check("out32_ovf", {31'b0, b32.out_ovf}, {31'b0, m32.ovf});
      end
    end
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL out8_unexpected: got 0x%02h, expected no result", b8.out_data);
      end else begin
        m8 = q8.pop_front();
        check("out8_data", {24'b0, b8.out_data}, m8.data);
        check("out8_ovf", {31'b0, b8.out_ovf}, {31'b0, m8.ovf});
      end
    end
  end

  function automatic logic rdy(input bit w8);
    return w8 ? b8.in_ready : b32.in_ready;
  endfunction

  function automatic logic ovld(input bit w8);
    return w8 ? b8.out_valid : b32.out_valid;
  endfunction

  task automatic drive(input bit w8, input logic [1:0] m, input logic [31:0] d, input logic v);
    if (w8) begin
      b8.in_valid = v; b8.mode = m; b8.in_data = d[7:0];
    end else begin
      b32.in_valid = v; b32.mode = m; b32.in_data = d;
    end
  endtask

  // Presents an operand until accepted; returns the cycle stamp of the accept edge.
  task automatic accept(input bit w8, input logic [1:0] m, input logic [31:0] d,
                        input bit push, input exp_t e, output int acc_cyc);
    acc_cyc = -1;
    drive(w8, m, d, 1'b1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy(w8)) begin
        if (push) begin
          if (w8) q8.push_back(e);
          else    q32.push_back(e);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        break;
      end
    end
    drive(w8, m, d, 1'b0);
    if (acc_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready never high, expected accept within 50 cycles");
    end
  endtask

  task automatic wait_out(input bit w8, input int acc_cyc, input int lat);
    for (int k = 0; k < 100; k++) begin
      if (ovld(w8)) break;
      @(posedge clk); #1;
    end
    check(w8 ? "latency8" : "latency32", cyc - acc_cyc, lat);
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   ac;
    e.data = v.exp;
    e.ovf  = v.ovf;
    accept(v.w8, v.mode, v.din, 1'b1, e, ac);
    if (ac >= 0) wait_out(v.w8, ac, v.w8 ? 1 : 4);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   ac;
    int   stray;
    int   delays[2];

    drive(1'b0, 2'b00, 32'h0, 1'b0);
    drive(1'b1, 2'b00, 32'h0, 1'b0);
    b32.out_ready = 1'b1;
    b8.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("rst_in_ready32",  {31'b0, b32.in_ready},  32'd1);
    check("rst_out_valid32", {31'b0, b32.out_valid}, 32'd0);
    check("rst_out_data32",  b32.out_data,           32'd0);
    check("rst_out_ovf32",   {31'b0, b32.out_ovf},   32'd0);
    check("rst_in_ready8",   {31'b0, b8.in_ready},   32'd1);
    check("rst_out_valid8",  {31'b0, b8.out_valid},  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{1'b0, 2'b01, 32'h000727AE, 32'hFFF8D852, 1'b0};
    vecs[1]  = '{1'b0, 2'b10, 32'hFFFFFFF6, 32'h0000000A, 1'b0};
    vecs[2]  = '{1'b0, 2'b10, 32'h00BB8FD7, 32'h00BB8FD7, 1'b0};
    vecs[3]  = '{1'b0, 2'b11, 32'h00599999, 32'h00599999, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 32'h00000000, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 32'h80000000, 32'h80000000, 1'b1};
    vecs[7]  = '{1'b0, 2'b10, 32'h80000000, 32'h80000000, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 32'h80000000, 32'h80000000, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
    vecs[10] = '{1'b0, 2'b01, 32'h00000100, 32'hFFFFFF00, 1'b0};
    vecs[11] = '{1'b1, 2'b01, 32'h000000AE, 32'h00000052, 1'b0};
    vecs[12] = '{1'b1, 2'b01, 32'h00000080, 32'h00000080, 1'b1};
    vecs[13] = '{1'b1, 2'b10, 32'h00000080, 32'h00000080, 1'b1};
    vecs[14] = '{1'b1, 2'b10, 32'h000000F6, 32'h0000000A, 1'b0};
    vecs[15] = '{1'b1, 2'b01, 32'h00000000, 32'h00000000, 1'b0};

    for (int i = 0; i < 16; i++) run(vecs[i]);

    // Backpressure: result held 5+ cycles; a waiting operand is taken only after the out handshake.
    b32.out_ready = 1'b0;
    e.data = 32'hEDCBA988; e.ovf = 1'b0;
    accept(1'b0, 2'b01, 32'h12345678, 1'b1, e, ac);
    if (ac >= 0) wait_out(1'b0, ac, 4);
    e.data = 32'hFFFFFFFB; e.ovf = 1'b0;
    q32.push_back(e);
    drive(1'b0, 2'b01, 32'h00000005, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, b32.out_valid}, 32'd1);
      check("bp_out_data",  b32.out_data,           32'hEDCBA988);
      check("bp_out_ovf",   {31'b0, b32.out_ovf},   32'd0);
      check("bp_in_ready",  {31'b0, b32.in_ready},  32'd0);
    end
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_after_hs", {31'b0, b32.out_valid}, 32'd0);
    check("bp_ready_after_hs", {31'b0, b32.in_ready},  32'd1);
    @(posedge clk); #1;
    ac = cyc;
    check("bp_second_taken", {31'b0, b32.in_ready}, 32'd0);
    drive(1'b0, 2'b01, 32'h00000005, 1'b0);
    wait_out(1'b0, ac, 4);
    @(posedge clk); #1;

    // Reset abort: once mid-BUSY, once in DONE with out_ready low.
    delays[0] = 2;
    delays[1] = 6;
    for (int r = 0; r < 2; r++) begin
      b32.out_ready = (r == 0);
      e.data = 32'h0; e.ovf = 1'b0;
      accept(1'b0, 2'b01, 32'h11111111, 1'b0, e, ac);
      repeat (delays[r]) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'b0, b32.out_valid}, 32'd0);
      check("abort_in_ready",  {31'b0, b32.in_ready},  32'd1);
      check("abort_out_data",  b32.out_data,           32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray = 0;
      repeat (6) begin
        @(negedge clk);
        if (b32.out_valid) stray++;
      end
      check("abort_no_stray_out", stray, 0);
      @(posedge clk); #1;
    end
    b32.out_ready = 1'b1;
    run('{1'b0, 2'b01, 32'h00FAE148, 32'hFF051EB8, 1'b0});

    check("q32_drained", q32.size(), 0);
    check("q8_drained",  q8.size(),  0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/compensate2_seq.md
Name: compensate2_seq

Overview:
- Parametrised, multi-cycle two's-complement unit; generalises the fixed 8/24/32-bit combinational negators.
- Processes the operand CHUNK bits per cycle with a registered carry chain, so wide operands avoid one long ripple path.
- Adds an operation mode (pass, negate, absolute value), an overflow flag and valid/ready handshakes on both sides.
- Sits between datapath stages (e.g. float mantissa alignment, ALU subtract paths) wherever a negated or absolute operand is needed.

Parameters:
- WIDTH, 32, operand width in bits; must be at least 2.
- CHUNK, 8, bits processed per cycle; must divide WIDTH exactly. CHUNK = WIDTH gives single-pass operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand and mode are valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand, two's complement.
- mode  input  2  operation: 00 pass, 01 negate, 10 absolute value, 11 pass.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  result is not representable; qualified by out_valid.

Behaviour:
- Define N = WIDTH/CHUNK.
- FSM states: IDLE, BUSY, DONE.
- Reset (asynchronous, immediate): state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_ovf = 0, chunk counter = 0, carry = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch in_data and compute neg = (mode == 01) or (mode == 10 and in_data[WIDTH-1]).
  - carry <= neg; ovf <= neg and (in_data == 1 followed by WIDTH-1 zeros); counter <= 0; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle take the lowest unprocessed CHUNK bits d and compute sum = (neg ? ~d : d) + carry, at CHUNK+1 bits wide.
  - Write the low CHUNK bits of sum into the result at the same bit position; carry <= sum[CHUNK].
  - Process chunks LSB first; the counter increments once per chunk.
  - After chunk N-1, go to DONE with out_valid = 1.
  - Carry out of the top chunk is discarded; result is modulo 2^WIDTH.
- DONE:
  - out_valid = 1; out_data and out_ovf are held stable; in_ready = 0.
  - When out_ready = 1, complete the transfer and go to IDLE (out_valid = 0 the next cycle).
- Latency: accepted on edge t, out_valid high after edge t+N. Minimum initiation interval N+2 cycles when out_ready is held high.
- Pass mode (00/11): out_data = in_data, out_ovf = 0; still takes N cycles.
- Negate of zero: carry ripples through every chunk; result 0, ovf 0.
- Most-negative input under negate or abs: out_data = 100...0, out_ovf = 1.
- in_valid asserted while in_ready = 0 is ignored. Upstream must hold in_valid/in_data until the handshake.
- out_data keeps its last result after the transfer until the next DONE; it is only meaningful while out_valid = 1.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. No partial result is emitted after reset release.
- Default generic build: WIDTH=32, CHUNK=8; WIDTH=8, 24, 32 with CHUNK=WIDTH must also elaborate.

Test Plan:
1. Negate 0x000727AE, out_ready=1 → out_data 0xFFF8D852, ovf 0; out_valid rises exactly 4 cycles after the accept edge.
2. Abs 0xFFFFFFF6 → 0x0000000A. Abs 0x00BB8FD7 → 0x00BB8FD7. Pass 0x0059999 9 (0x00599999) with mode 11 → unchanged. All with ovf 0.
3. Negate 0x00000000 → 0x00000000, ovf 0; negate 0x00000001 → 0xFFFFFFFF.
4. Negate 0x80000000 → 0x80000000, ovf 1; abs 0x80000000 → 0x80000000, ovf 1.
5. Backpressure: out_ready low 5 cycles in DONE:
   - out_data and ovf stay stable; in_ready stays 0.
   - A second in_valid presented meanwhile is not accepted until the cycle after the out handshake.
6. Reset mid-op: pull rst_n low 2 cycles after accept:
   - out_valid goes 0 and in_ready goes 1 immediately.
   - After release, negate 0x00FAE148 → 0xFF051EB8 with the correct latency.
   - Repeat tests 1 and 4 with WIDTH=8, CHUNK=8 (latency 1).
